// File: rtl/seg7_display_driver.sv
// Four-digit multiplexed seven-segment driver for the core's 16-bit display register.
// Writes are held pending and committed only at a scan-frame boundary so digits never tear.
module seg7_display_driver #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic        blank_lz,
    output logic        wr_ack,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] pcnt;
    logic [1:0]    idx;
    logic [15:0]   disp;
    logic [15:0]   pend_data;
    logic          pend_valid;
    logic          tick;
    logic          commit;
    logic [3:0]    nib;
    logic          blank;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 7'h40;
            4'h1: enc = 7'h79;
            4'h2: enc = 7'h24;
            4'h3: enc = 7'h30;
            4'h4: enc = 7'h19;
            4'h5: enc = 7'h12;
            4'h6: enc = 7'h02;
            4'h7: enc = 7'h78;
            4'h8: enc = 7'h00;
            4'h9: enc = 7'h10;
            4'hA: enc = 7'h08;
            4'hB: enc = 7'h03;
            4'hC: enc = 7'h46;
            4'hD: enc = 7'h21;
            4'hE: enc = 7'h06;
            default: enc = 7'h0E;
        endcase
    endfunction

    assign tick   = (pcnt == PMAX);
    assign commit = tick && (idx == 2'd3) && pend_valid;
    assign nib    = 4'(disp >> {idx, 2'b00});

    // A digit is blanked only if it and every more-significant nibble are zero.
    always_comb begin
        blank = 1'b0;
        if (blank_lz) begin
            case (idx)
                2'd1:    blank = (disp[15:4] == 12'h000);
                2'd2:    blank = (disp[15:8] == 8'h00);
                2'd3:    blank = (disp[15:12] == 4'h0);
                default: blank = 1'b0;
            endcase
        end
    end

    always_comb begin
        an_next  = ~(4'b0001 << idx);
        seg_next = enc(nib);
        if (blank) begin
            an_next  = 4'b1111;
            seg_next = 7'h7F;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt       <= '0;
            idx        <= 2'd0;
            disp       <= 16'h0000;
            pend_data  <= 16'h0000;
            pend_valid <= 1'b0;
            wr_ack     <= 1'b0;
            an         <= 4'b1111;
            seg        <= 7'h7F;
        end else begin
            pcnt   <= tick ? '0 : pcnt + 1'b1;
            idx    <= tick ? idx + 2'd1 : idx;
            wr_ack <= commit;
            an     <= an_next;
            seg    <= seg_next;
            if (commit) begin
                disp <= pend_data;
            end
            // A write landing on the commit edge stays pending for the next frame.
            if (wr_en) begin
                pend_data  <= wr_data;
                pend_valid <= 1'b1;
            end else if (commit) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_display_driver.sv
// Directed bench for seg7_display_driver with REFRESH_DIV=4; t counts edges since reset release.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_seg7_display_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = 16'h0000;
    logic        blank_lz = 1'b0;
    logic        wr_ack;
    logic [3:0]  an;
    logic [6:0]  seg;

    int t = 0;
    int ack_cnt = 0;
    int errors = 0;
    int checks = 0;

    seg7_display_driver #(.REFRESH_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .blank_lz (blank_lz),
        .wr_ack   (wr_ack),
        .an       (an),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) t <= 0;
        else     t <= t + 1;
    end

    always @(negedge clk) begin
        if (wr_ack === 1'b1) ack_cnt++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e);
        chk({tag, ".an"}, {12'h0, an}, {12'h0, an_e});
        chk({tag, ".seg"}, {9'h0, seg}, {9'h0, seg_e});
    endtask

    task automatic wait_t(input int target);
        int guard;
        guard = 0;
        while (t < target && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (t != target) begin
            checks++;
            errors++;
            $error("FAIL wait_t observed=%0d expected=%0d", t, target);
        end
    endtask

    task automatic write_at(input int when, input logic [15:0] d);
        wait_t(when);
        wr_en   = 1'b1;
        wr_data = d;
        wait_t(when + 1);
        wr_en   = 1'b0;
    endtask

    int acks0;

    initial begin
        // reset held for two edges
        @(posedge clk); #1;
        chk_out("rst0", 4'b1111, 7'h7F);
        chk("rst0.ack", {15'h0, wr_ack}, 16'h0);
        @(posedge clk); #1;
        chk_out("rst1", 4'b1111, 7'h7F);
        rst = 1'b0;

        wait_t(1);  chk_out("scan.d0", 4'b1110, 7'h40);
        wait_t(4);  chk_out("scan.d0end", 4'b1110, 7'h40);
        wait_t(5);  chk_out("scan.d1", 4'b1101, 7'h40);
        wait_t(9);  chk_out("scan.d2", 4'b1011, 7'h40);
        wait_t(13); chk_out("scan.d3", 4'b0111, 7'h40);
        wait_t(17); chk_out("scan.wrap", 4'b1110, 7'h40);

        // basic write 1234, committed at edge 32
        write_at(20, 16'h1234);
        wait_t(31); chk("basic.ack_pre", {15'h0, wr_ack}, 16'h0);
        wait_t(32); chk("basic.ack", {15'h0, wr_ack}, 16'h1);
        wait_t(33); chk("basic.ack_post", {15'h0, wr_ack}, 16'h0);
        chk_out("basic.d0", 4'b1110, 7'h19);
        wait_t(37); chk_out("basic.d1", 4'b1101, 7'h30);
        wait_t(41); chk_out("basic.d2", 4'b1011, 7'h24);
        wait_t(45); chk_out("basic.d3", 4'b0111, 7'h79);
        chk("basic.ackcnt", 16'(ack_cnt), 16'd1);

        // last write wins, leading-zero blanking on
        blank_lz = 1'b1;
        write_at(50, 16'hAAAA);
        write_at(53, 16'h00F0);
        wait_t(64); chk("lww.ack", {15'h0, wr_ack}, 16'h1);
        wait_t(65); chk_out("lww.d0", 4'b1110, 7'h40);
        wait_t(69); chk_out("lww.d1", 4'b1101, 7'h0E);
        wait_t(73); chk_out("lww.d2", 4'b1111, 7'h7F);
        wait_t(77); chk_out("lww.d3", 4'b1111, 7'h7F);
        chk("lww.ackcnt", 16'(ack_cnt), 16'd2);

        // all-zero display
        write_at(80, 16'h0000);
        wait_t(97);  chk_out("zero.d0", 4'b1110, 7'h40);
        wait_t(101); chk_out("zero.d1", 4'b1111, 7'h7F);
        wait_t(105); chk_out("zero.d2", 4'b1111, 7'h7F);
        wait_t(109); chk_out("zero.d3", 4'b1111, 7'h7F);
        wait_t(112); blank_lz = 1'b0;
        wait_t(113); chk_out("zero.nb0", 4'b1110, 7'h40);
        wait_t(117); chk_out("zero.nb1", 4'b1101, 7'h40);
        blank_lz = 1'b1;
        wait_t(118); chk_out("zero.blank1cyc", 4'b1111, 7'h7F);
        blank_lz = 1'b0;
        wait_t(119); chk_out("zero.unblank1cyc", 4'b1101, 7'h40);
        wait_t(121); chk_out("zero.nb2", 4'b1011, 7'h40);
        wait_t(125); chk_out("zero.nb3", 4'b0111, 7'h40);
        chk("zero.ackcnt", 16'(ack_cnt), 16'd3);

        // write coinciding with the commit edge (144)
        write_at(130, 16'h5555);
        write_at(143, 16'h6666);
        chk("coin.ack1", {15'h0, wr_ack}, 16'h1);
        wait_t(145); chk_out("coin.d0", 4'b1110, 7'h12);
        wait_t(157); chk_out("coin.d3", 4'b0111, 7'h12);
        wait_t(159); chk("coin.ack_pre", {15'h0, wr_ack}, 16'h0);
        wait_t(160); chk("coin.ack2", {15'h0, wr_ack}, 16'h1);
        wait_t(161); chk_out("coin.new_d0", 4'b1110, 7'h02);
        wait_t(165); chk_out("coin.new_d1", 4'b1101, 7'h02);
        chk("coin.ackcnt", 16'(ack_cnt), 16'd5);

        // reset with pending data; a write during reset is ignored
        write_at(168, 16'hBEEF);
        wait_t(170);
        acks0 = ack_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_out("rst2.a", 4'b1111, 7'h7F);
        wr_en   = 1'b1;
        wr_data = 16'hFFFF;
        @(posedge clk); #1;
        chk_out("rst2.b", 4'b1111, 7'h7F);
        chk("rst2.ack", {15'h0, wr_ack}, 16'h0);
        rst   = 1'b0;
        wr_en = 1'b0;
        wait_t(1);  chk_out("rst2.d0", 4'b1110, 7'h40);
        wait_t(5);  chk_out("rst2.d1", 4'b1101, 7'h40);
        wait_t(13); chk_out("rst2.d3", 4'b0111, 7'h40);
        wait_t(17); chk_out("rst2.wrap", 4'b1110, 7'h40);
        wait_t(36); chk("rst2.noack", 16'(ack_cnt - acks0), 16'd0);
        chk_out("rst2.late", 4'b1110, 7'h40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_display_driver.md
# seg7_display_driver

Reader side of the processor's display register. The core writes a 16-bit value through a single-cycle write strobe. This block holds the value in a pending register, commits it to the display at a scan-frame boundary so the digits never tear, and time-multiplexes it onto four hex digits of the board's seven-segment display. It drives the top-level `an` anode bus and a matching segment bus, and acknowledges each commit.

## Interface
Parameters:
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit. Legal range is 2 or more. Benches use 4.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write strobe; one cycle per write.
- `wr_data`  in  16  value to display; four hex nibbles, `[3:0]` is the rightmost digit.
- `blank_lz`  in  1  leading-zero blanking enable; sampled every cycle.
- `wr_ack`  out  1  one-cycle pulse when a pending value is committed to the display.
- `an`  out  4  anode enables, active-low; `an[0]` is the rightmost digit.
- `seg`  out  7  segment cathodes, active-low, ordered `{g,f,e,d,c,b,a}`.

## Operation
- **Prescaler** `pcnt`: counts 0 to REFRESH_DIV-1 and wraps to 0. `tick` is asserted when `pcnt == REFRESH_DIV-1`.
- **Digit index** `idx` (2 bits): increments on `tick` and wraps 3→0. A frame is idx 0,1,2,3.
- **Pending register**:
  - `wr_en` loads `pend_data <= wr_data` and sets `pend_valid <= 1`.
  - A write while `pend_valid` is already set overwrites the data (last write wins). Only one ack is produced.
- **Commit**: on a `tick` with `idx == 3` and `pend_valid == 1`:
  - `disp <= pend_data` and `pend_valid <= 0`.
  - `wr_ack` goes high in the next cycle for exactly one cycle.
- **Write on the commit cycle**: if `wr_en` coincides with the commit tick, the previously pending data is committed. The new data becomes pending (`pend_valid` stays 1) and is committed one frame later.
- **Nibble selection**: `nib = disp[4*idx +: 4]`.
- **Hex encoding** (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (all hex).
- **Blanking**: digit idx>0 is blanked when `blank_lz == 1` and all nibbles of `disp` from idx up to 3 are zero. A blanked digit drives `an = 4'b1111` and `seg = 7'h7F`. Digit 0 is never blanked.
- **Unblanked output**: `an = ~(4'b0001 << idx)`, `seg = enc(nib)`.
- **Output registers**: `an` and `seg` are registered and recomputed every cycle from the current `idx`, `disp` and `blank_lz`.

## Timing
- **Reset values**: `pcnt=0`, `idx=0`, `disp=16'h0000`, `pend_data=0`, `pend_valid=0`, `wr_ack=0`, `an=4'b1111`, `seg=7'h7F`.
- **After reset release**: at the first edge, `an=4'b1110` and `seg=7'h40`.
- **Output latency**: `an`/`seg` lag `idx` and `disp` by exactly 1 cycle.
- **Digit and frame timing**: each digit is lit for exactly REFRESH_DIV cycles. A frame is 4·REFRESH_DIV cycles.
- **Write-to-display latency**:
  - Write to commit: 1 cycle minimum, 4·REFRESH_DIV cycles maximum.
  - Commit to `wr_ack`: +1 cycle.
  - The new value first appears on `seg` at the first edge after commit, on digit 0.
- **Reset mid-operation**: reset in any cycle has these effects:
  - Drops pending data; no `wr_ack` is produced.
  - Returns the display to 0.
  - Restarts the frame at idx 0.
  - `wr_en` during reset is ignored.
- **blank_lz changes**: take effect on the next output update (1 cycle). They never affect commit timing.

## Test plan
All scenarios use REFRESH_DIV=4.
- **Reset**: hold `rst` 2 cycles → `an=1111`, `seg=7F` throughout. At the first edge after release, `an=1110`, `seg=40`. Digit steps occur every 4 cycles: 1110→1101→1011→0111→1110.
- **Basic write**: write 16'h1234 (`blank_lz=0`) mid-frame → exactly one `wr_ack` pulse, 1 cycle after the idx3→0 tick. The following frame shows:
  - `an=1110` with `seg=19`
  - `an=1101` with `seg=30`
  - `an=1011` with `seg=24`
  - `an=0111` with `seg=79`
- **Last write wins**: write 16'hAAAA, then 16'h00F0, within one frame (`blank_lz=1`) → one ack. Display shows:
  - digit0 `seg=40`
  - digit1 `seg=0E`
  - digits 2 and 3 blanked: `an=1111`, `seg=7F`
- **All-zero blanking**: write 16'h0000 with `blank_lz=1` → only digit 0 is lit (`an=1110`, `seg=40`). The other three slots show `an=1111`. Setting `blank_lz=0` lights all four with `seg=40`.
- **Write on commit tick**: assert `wr_en` with 16'h5555 pending and 16'h6666 on the commit cycle → ack, display 5555. A second ack follows exactly 16 cycles later, with display 6666.
- **Reset with pending data**: write 16'hBEEF, then assert `rst` before the frame boundary → no `wr_ack`. Display shows 0000 after release.
